// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and line constants, common to the
// transmitter and the future receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    // 100 MHz system clock at 115200 baud.
    localparam int unsigned DefaultClksPerBit = 868;
    localparam logic        IdleLevel         = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// Byte valid/ready handshake between an on-chip producer and the UART transmitter.
interface uart_tx_if #(
    parameter int unsigned DATA_BITS = 8
) ();

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: bit_tick marks the last clock of each CLKS_PER_BIT-cycle bit period;
// clear holds the count at 0 so the next period starts aligned.
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = uart_pkg::DefaultClksPerBit
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_tick
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        bit_tick = (cnt_q == LastCnt);
        if (clear || bit_tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Byte-wide UART transmitter, 8N1 LSB first over a valid/ready handshake.
// Defining UART_TX_PARITY_EN inserts an even-parity bit (8E1).
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic      clk,
    input  logic      reset,
    uart_tx_if.slave  bus,
    output logic      tx,
    output logic      busy
);

    localparam int unsigned IdxW = $clog2(DATA_BITS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic                 tx_q, tx_d;
    logic                 ready;
    logic                 accept;
    logic                 baud_clear;
    logic                 bit_tick;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk      (clk),
        .reset    (reset),
        .clear    (baud_clear),
        .bit_tick (bit_tick)
    );

    assign ready        = (state_q == StIdle);
    assign accept       = ready && bus.tx_valid;
    assign bus.tx_ready = ready;
    assign busy         = ~ready;
    assign tx           = tx_q;

`ifdef UART_TX_PARITY_EN
    logic parity_q, parity_d;

    // Parity is fixed at the accept edge so later tx_data changes cannot affect it.
    assign parity_d = accept ? ^bus.tx_data : parity_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        baud_clear = 1'b0;
        unique case (state_q)
            StIdle: begin
                baud_clear = 1'b1;
                if (accept) begin
                    state_d = StStart;
                    shift_d = bus.tx_data;
                end
            end
            StStart: begin
                if (bit_tick) begin
                    state_d = StData;
                    idx_d   = '0;
                end
            end
            StData: begin
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == LastIdx) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_tick) begin
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (bit_tick) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line level follows the next state so the pin is registered yet aligned with the FSM.
    always_comb begin
        tx_d = IdleLevel;
        unique case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            StParity: tx_d = parity_q;
`endif
            default: tx_d = IdleLevel;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= IdleLevel;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4; a line monitor decodes frames against a
// scoreboard queue. Define UART_TX_PARITY_EN for both RTL and bench to cover 8E1.
module tb_uart_tx;

    localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned PAR = 1;
`else
    localparam int unsigned PAR = 0;
`endif
    localparam int unsigned NB        = 10 + PAR;
    localparam int unsigned FRAME_CYC = NB * CPB;

    logic clk;
    logic reset;
    logic tx;
    logic busy;

    uart_tx_if #(.DATA_BITS(8)) bus ();

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .tx    (tx),
        .busy  (busy)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int acc_cyc = 0;
    logic [7:0] exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && bus.tx_valid && bus.tx_ready) begin
            acc_cnt <= acc_cnt + 1;
            acc_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line monitor: each frame is sampled on every negedge so bit-hold is checked too.
    always begin
        @(negedge clk);
        if (!reset && tx === 1'b0) begin : frame
            logic [NB-1:0] lv;
            logic [7:0]    got;
            logic [7:0]    want;
            bit            held;
            bit            abort;
            lv    = '0;
            held  = 1'b1;
            abort = 1'b0;
            for (int b = 0; b < int'(NB); b++) begin
                for (int c = 0; c < int'(CPB); c++) begin
                    if (b != 0 || c != 0) @(negedge clk);
                    if (reset) abort = 1'b1;
                    if (!abort) begin
                        if (c == 0) lv[b] = tx;
                        else if (tx !== lv[b]) held = 1'b0;
                    end
                end
            end
            if (!abort) begin
                got = lv[8:1];
                chk("frame_start_stop", {lv[0], lv[NB-1]}, 2'b01);
                chk("bit_hold", held, 1'b1);
                chk("frame_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    want = exp_q.pop_front();
                    chk("frame_data", got, want);
                    if (PAR != 0) chk("parity_bit", lv[9], ^want);
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input bit push, input bit drop_valid);
        int n0;
        n0 = acc_cnt;
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        if (push) exp_q.push_back(d);
        for (int i = 0; i < 300 && acc_cnt == n0; i++) @(negedge clk);
        chk("accept", acc_cnt != n0, 1'b1);
        if (drop_valid) bus.tx_valid = 1'b0;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 300 && bus.tx_ready !== 1'b1; i++) @(negedge clk);
        chk("ready_timeout", bus.tx_ready, 1'b1);
    endtask

    // Called on the first negedge after the accept edge; checks every cycle of the frame.
    task automatic check_frame(input logic [7:0] d);
        logic exp_lvl;
        int   b;
        for (int c = 1; c <= int'(FRAME_CYC); c++) begin
            if (c != 1) @(negedge clk);
            b = (c - 1) / int'(CPB);
            if (b == 0) exp_lvl = 1'b0;
            else if (b <= 8) exp_lvl = d[b-1];
            else if (PAR != 0 && b == 9) exp_lvl = ^d;
            else exp_lvl = 1'b1;
            chk("frame_tx_level", tx, exp_lvl);
            chk("frame_busy", {bus.tx_ready, busy}, 2'b01);
        end
        @(negedge clk);
        chk("ready_after_frame", {bus.tx_ready, busy, tx}, 3'b101);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t1;
        int n0;
        int hi_run;

        reset        = 1'b1;
        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", {tx, bus.tx_ready, busy}, 3'b110);
        reset = 1'b0;

        // Idle line after reset.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_line", {tx, bus.tx_ready, busy}, 3'b110);
        end

        // Single 0x55 frame, checked cycle by cycle.
        send(8'h55, 1'b1, 1'b1);
        check_frame(8'h55);
        repeat (3) @(negedge clk);

        // 0x00 then 0xFF with tx_valid held: one idle cycle between frames.
        send(8'h00, 1'b1, 1'b0);
        t1 = acc_cyc;
        bus.tx_data = 8'hFF;
        exp_q.push_back(8'hFF);
        n0 = acc_cnt;
        hi_run = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (acc_cnt != n0) break;
            hi_run = (tx === 1'b1) ? hi_run + 1 : 0;
        end
        bus.tx_valid = 1'b0;
        chk("b2b_accept", acc_cnt, n0 + 1);
        chk("b2b_spacing", acc_cyc - t1, FRAME_CYC + 1);
        chk("b2b_high_run", hi_run, CPB + 1);
        chk("b2b_start", tx, 1'b0);
        wait_ready();
        repeat (3) @(negedge clk);

        // 0xA5 with tx_data change and a valid pulse mid-frame: ignored.
        n0 = acc_cnt;
        send(8'hA5, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        bus.tx_data  = 8'h3C;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        wait_ready();
        repeat (CPB * 3) @(negedge clk);
        chk("no_extra_frame", acc_cnt, n0 + 1);
        chk("idle_after_a5", {tx, bus.tx_ready}, 2'b11);

        // Reset during data bit 3 of 0xF0; the aborted frame is never expected.
        send(8'hF0, 1'b0, 1'b1);
        repeat (17) @(negedge clk);
        chk("bit3_before_reset", tx, 1'b0);
        #2 reset = 1'b1;
        #1 chk("async_reset_tx", {tx, bus.tx_ready, busy}, 3'b110);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n0 = acc_cnt;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            chk("post_reset_idle", {tx, bus.tx_ready, busy}, 3'b110);
        end
        chk("post_reset_no_accept", acc_cnt, n0);

`ifdef UART_TX_PARITY_EN
        send(8'h07, 1'b1, 1'b1);
        check_frame(8'h07);
        repeat (3) @(negedge clk);
`endif

        repeat (CPB * 2) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
